// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl_if
//  Description : Command handshake plus 194-style shift register control bus
//                between the requester, the sequencer and the shift datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if #(
    parameter int AMT_W  = 5,
    parameter int DATA_W = 32
);
    // requester side
    logic              start;
    logic [2:0]        op;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    // shift register side
    logic [DATA_W-1:0] Q;
    logic              S1;
    logic              S0;
    logic              SL;
    logic              SR;
    logic [DATA_W-1:0] PData;
    logic              sh_clear;

    // Environment: drives commands and returns the register contents
    modport master (
        output start, op, amt, data_in, Q,
        input  busy, done, S1, S0, SL, SR, PData, sh_clear
    );

    // Sequencer
    modport slave (
        input  start, op, amt, data_in, Q,
        output busy, done, S1, S0, SL, SR, PData, sh_clear
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Sequences one load/shift/rotate/clear command onto a 32-bit
//                194-style shift register, one shift per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int AMT_W  = 5,
    parameter int DATA_W = 32
) (
    input  wire logic clk,
    input  wire logic CR,
    shift_seq_ctrl_if.slave bus
);

    localparam logic [2:0] c_OP_LOAD = 3'b000;
    localparam logic [2:0] c_OP_SLL  = 3'b001;
    localparam logic [2:0] c_OP_SRL  = 3'b010;
    localparam logic [2:0] c_OP_SRA  = 3'b011;
    localparam logic [2:0] c_OP_ROL  = 3'b100;
    localparam logic [2:0] c_OP_ROR  = 3'b101;
    localparam logic [2:0] c_OP_CLR  = 3'b110;
    localparam logic [2:0] c_OP_NOP  = 3'b111;

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT = 2'b01;
    localparam logic [1:0] c_MODE_LEFT  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [AMT_W-1:0]  r_amt;
    logic [AMT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;

    logic [1:0]        w_mode;
    logic              w_sl;
    logic              w_sr;
    logic [DATA_W-1:0] w_pdata;
    logic              w_load_only;

    // Commands that finish after the parallel load with no shifting
    assign w_load_only = (r_op == c_OP_LOAD) || (r_op == c_OP_CLR) ||
                         (r_amt == '0);

    always_ff @(posedge clk or negedge CR) begin
        if (!CR) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_amt   <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_amt   <= bus.amt;
                        r_data  <= bus.data_in;
                        r_state <= (bus.op == c_OP_NOP) ? ST_DONE : ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_load_only) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_amt;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Register control decoded from registered state; SL/SR may follow Q for fill
    always_comb begin
        w_mode  = c_MODE_HOLD;
        w_sl    = 1'b0;
        w_sr    = 1'b0;
        w_pdata = '0;
        case (r_state)
            ST_LOAD: begin
                w_mode  = c_MODE_LOAD;
                w_pdata = (r_op == c_OP_CLR) ? '0 : r_data;
            end
            ST_SHIFT: begin
                case (r_op)
                    c_OP_SLL: w_mode = c_MODE_LEFT;
                    c_OP_SRL: w_mode = c_MODE_RIGHT;
                    c_OP_SRA: begin
                        w_mode = c_MODE_RIGHT;
                        w_sr   = bus.Q[DATA_W-1];
                    end
                    c_OP_ROL: begin
                        w_mode = c_MODE_LEFT;
                        w_sl   = bus.Q[DATA_W-1];
                    end
                    c_OP_ROR: begin
                        w_mode = c_MODE_RIGHT;
                        w_sr   = bus.Q[0];
                    end
                    default: w_mode = c_MODE_HOLD;
                endcase
            end
            default: w_mode = c_MODE_HOLD;
        endcase
    end

    assign bus.S1       = w_mode[1];
    assign bus.S0       = w_mode[0];
    assign bus.SL       = w_sl;
    assign bus.SR       = w_sr;
    assign bus.PData    = w_pdata;
    assign bus.busy     = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign bus.done     = (r_state == ST_DONE);
    // System reset also wipes the shift register
    assign bus.sh_clear = ~CR;

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the 32-bit 194-based shift register.
- Accepts one operation command (load, logical/arithmetic shift, rotate, clear) with a shift amount, then drives the register's mode pins S1/S0, serial inputs SL/SR and parallel data cycle by cycle.
- Signals completion to the requester.
- Sits between the calculator control logic and the shift datapath; reads the register output Q back for rotate/arithmetic fill.

Parameters:
- AMT_W, 5, width of shift amount (max shift 2^AMT_W-1 = 31)
- DATA_W, 32, datapath width; fixed at 32, other values unsupported

Ports:
- clk  in  1  system clock, rising edge
- CR  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled in IDLE/DONE only
- op  in  3  operation code, captured with start
- amt  in  AMT_W  shift count, captured with start
- data_in  in  32  operand, captured with start
- Q  in  32  current shift register contents (feedback)
- S1  out  1  register mode bit 1
- S0  out  1  register mode bit 0
- SL  out  1  serial input entering Q[0] on left shift
- SR  out  1  serial input entering Q[31] on right shift
- PData  out  32  parallel load data
- sh_clear  out  1  active-high clear to the shift register
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse; Q valid

Behaviour:
- Register mode codes (S1,S0):
  - 00 hold
  - 01 shift right: Q[i] <= Q[i+1], Q[31] <= SR
  - 10 shift left: Q[i] <= Q[i-1], Q[0] <= SL
  - 11 parallel load: Q <= PData
- op encoding:
  - 000 LOAD
  - 001 SLL
  - 010 SRL
  - 011 SRA
  - 100 ROL
  - 101 ROR
  - 110 CLR (loads zero)
  - 111 NOP
- sh_clear = ~CR, combinational, so system reset also clears the shifter.
- FSM states: IDLE, LOAD, SHIFT, DONE. All state, op_r, amt_r, data_r and cnt registered; async reset to IDLE with op_r=0, amt_r=0, data_r=0, cnt=0.
- Outputs are combinational from registered state only; no combinational path from start/op to S1/S0.
  - Reset values: S1=S0=0, SL=SR=0, PData=0, busy=0, done=0.
- IDLE / DONE: S1S0=00 (hold).
  - start=1 at an edge: capture op/amt/data_in, go to LOAD.
  - Exception: op=NOP goes to DONE directly with no register change.
- LOAD: S1S0=11, PData=data_r (0 for CLR).
  - Next state is DONE if op is LOAD, CLR, or amt_r=0; otherwise SHIFT with cnt<=amt_r.
- SHIFT: one shift per clock. cnt decrements each edge; the edge with cnt=1 moves to DONE.
  - SLL: S1S0=10, SL=0
  - SRL: S1S0=01, SR=0
  - SRA: S1S0=01, SR=Q[31]
  - ROL: S1S0=10, SL=Q[31]
  - ROR: S1S0=01, SR=Q[0]
  - Unused serial input is driven 0.
- DONE: done=1 for exactly one cycle. Without start, return to IDLE. With start, accept the new command (back-to-back allowed).
- busy=1 in LOAD and SHIFT, else 0. start while busy is ignored; no queuing.
- Latency: done is high in the cycle following the (2+amt)-th edge after the start edge for shift ops; after 2 edges for LOAD/CLR/amt=0; after 1 edge for NOP.
- PData outside LOAD = 0. In SHIFT, PData is not consumed.
- CR asserted mid-operation: FSM returns to IDLE immediately and the shifter is cleared via sh_clear. No done pulse is emitted.
- Unknown/X op is not a legal input; all 8 codes are defined.

Test Plan:
- Reset: CR=0 at mid-SHIFT (SLL amt=20, after 5 shifts) -> busy=0, done=0, S1S0=00, sh_clear=1, Q=0. After release, IDLE.
- LOAD: start, op=000, data_in=0xDEADBEEF -> S1S0=11 for one cycle; done after 2 edges; Q=0xDEADBEEF; busy high 1 cycle.
- SLL/SRL: op=001, amt=4, data=0x8000000F -> Q=0x000000F0, done at edge 6. op=010, amt=31, data=0x80000000 -> Q=0x00000001.
- SRA/ROR/ROL:
  - op=011, amt=8, data=0x80001234 -> Q=0xFF800012.
  - op=101, amt=4, data=0x0000000A -> Q=0xA0000000.
  - op=100, amt=1, data=0x80000001 -> Q=0x00000003.
- Boundaries:
  - SLL amt=0, data=0x1234 -> Q=0x1234, done after 2 edges.
  - NOP -> done after 1 edge, Q unchanged.
  - CLR -> Q=0.
- Handshake: start pulsed during busy (ignored, result matches first command). Start in DONE cycle with SRL amt=2 -> accepted, no IDLE cycle; second done after 4 more edges.
